// File: rtl/ntsc_line_buffer_pkg.sv
// ntsc_line_buffer_pkg: shared sizes, write FSM encoding and counter limit for the line buffer
package ntsc_line_buffer_pkg;
  localparam int DEF_PIX_W = 5;
  localparam int DEF_LINE_PIX = 188;
  localparam int DEF_COL_W = 8;
  localparam logic [7:0] UNDERRUN_MAX = 8'd255;
  typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_FULL} wr_state_e;
endpackage

// File: rtl/ntsc_line_bank.sv
// ntsc_line_bank: one line of pixel storage, synchronous write and registered read
module ntsc_line_bank #(
  parameter int PIX_W = 5,
  parameter int LINE_PIX = 188,
  parameter int COL_W = 8
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [COL_W-1:0] waddr_i,
  input  logic [PIX_W-1:0] wdata_i,
  input  logic [COL_W-1:0] raddr_i,
  output logic [PIX_W-1:0] rdata_o
);
  logic [PIX_W-1:0] mem_q [LINE_PIX];
  logic [PIX_W-1:0] rdata_q;
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_q <= mem_q[raddr_i];
  end
  assign rdata_o = rdata_q;
endmodule

// File: rtl/ntsc_line_buffer.sv
// ntsc_line_buffer: ping-pong line buffer feeding the luma timing stage; one bank fills while the other is read
module ntsc_line_buffer
  import ntsc_line_buffer_pkg::*;
#(
  parameter int PIX_W = DEF_PIX_W,
  parameter int LINE_PIX = DEF_LINE_PIX,
  parameter int COL_W = DEF_COL_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [PIX_W-1:0] wr_data_i,
  input  logic             wr_valid_i,
  input  logic             wr_sol_i,
  output logic             wr_ready_o,
  output logic             req_line_o,
  input  logic             line_start_i,
  input  logic [COL_W-1:0] rd_col_i,
  output logic [PIX_W-1:0] rd_pixel_o,
  output logic [7:0]       underrun_cnt_o,
  output logic             sync_err_o
);
  wr_state_e state_q, state_d;
  logic [COL_W-1:0] ptr_q, ptr_d, waddr;
  logic [7:0] cnt_q, cnt_d;
  logic rd_bank_q, rd_bank_d, blank_q, blank_d, ready_q, ready_d, req_q, req_d;
  logic sync_q, sync_d, zero_q, zero_d, sel_q, init_q;
  logic accept, last, swap, we;
  logic [PIX_W-1:0] rdata0, rdata1;
  always_comb begin
    accept = wr_valid_i && ready_q;
    last = accept && state_q == ST_FILL && !wr_sol_i && ptr_q == COL_W'(LINE_PIX - 1);
    swap = line_start_i && (state_q == ST_FULL || last);
    we = accept && (wr_sol_i || state_q == ST_FILL);
    waddr = wr_sol_i ? '0 : ptr_q;
    ptr_d = (accept && wr_sol_i) ? COL_W'(1) : we ? ptr_q + 1'b1 : ptr_q;
    state_d = swap ? ST_IDLE : last ? ST_FULL : (accept && wr_sol_i) ? ST_FILL : state_q;
    rd_bank_d = rd_bank_q ^ swap;
    blank_d = swap ? 1'b0 : line_start_i ? 1'b1 : blank_q;
    cnt_d = (line_start_i && !swap && cnt_q != UNDERRUN_MAX) ? cnt_q + 8'd1 : cnt_q;
    sync_d = sync_q || (accept && state_q == ST_FILL && wr_sol_i);
    ready_d = state_d != ST_FULL;
    req_d = init_q || swap;
    // blank and the swap are seen by reads one cycle after line_start_i
    zero_d = blank_q || rd_col_i >= COL_W'(LINE_PIX);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      ptr_q <= '0;
      rd_bank_q <= 1'b0;
      blank_q <= 1'b1;
      ready_q <= 1'b0;
      req_q <= 1'b0;
      init_q <= 1'b1;
      cnt_q <= '0;
      sync_q <= 1'b0;
      sel_q <= 1'b0;
      zero_q <= 1'b1;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      rd_bank_q <= rd_bank_d;
      blank_q <= blank_d;
      ready_q <= ready_d;
      req_q <= req_d;
      init_q <= 1'b0;
      cnt_q <= cnt_d;
      sync_q <= sync_d;
      sel_q <= rd_bank_q;
      zero_q <= zero_d;
    end
  end
  ntsc_line_bank #(.PIX_W(PIX_W), .LINE_PIX(LINE_PIX), .COL_W(COL_W)) u_bank0 (
    .clk_i(clk_i), .we_i(we && rd_bank_q), .waddr_i(waddr), .wdata_i(wr_data_i),
    .raddr_i(rd_col_i), .rdata_o(rdata0)
  );
  ntsc_line_bank #(.PIX_W(PIX_W), .LINE_PIX(LINE_PIX), .COL_W(COL_W)) u_bank1 (
    .clk_i(clk_i), .we_i(we && !rd_bank_q), .waddr_i(waddr), .wdata_i(wr_data_i),
    .raddr_i(rd_col_i), .rdata_o(rdata1)
  );
  assign wr_ready_o = ready_q;
  assign req_line_o = req_q;
  assign rd_pixel_o = zero_q ? '0 : (sel_q ? rdata1 : rdata0);
  assign underrun_cnt_o = cnt_q;
  assign sync_err_o = sync_q;
endmodule

// File: tb/tb_ntsc_line_buffer.sv
// tb_ntsc_line_buffer: directed checks of fill, swap, underrun, sync error and reset behaviour
module tb_ntsc_line_buffer;
  logic clk = 0, rst = 1;
  logic [4:0] wr_data = 0;
  logic wr_valid = 0, wr_sol = 0, line_start = 0;
  logic [7:0] rd_col = 0;
  logic wr_ready, req_line, sync_err;
  logic [4:0] rd_pixel;
  logic [7:0] underrun_cnt;
  int vectors = 0, miscompares = 0;

  ntsc_line_buffer dut (
    .clk_i(clk), .rst_i(rst), .wr_data_i(wr_data), .wr_valid_i(wr_valid), .wr_sol_i(wr_sol),
    .wr_ready_o(wr_ready), .req_line_o(req_line), .line_start_i(line_start), .rd_col_i(rd_col),
    .rd_pixel_o(rd_pixel), .underrun_cnt_o(underrun_cnt), .sync_err_o(sync_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [4:0] d, input logic s);
    wr_valid = 1; wr_data = d; wr_sol = s;
    step();
    wr_valid = 0; wr_sol = 0;
  endtask

  task automatic pulse_line();
    line_start = 1;
    step();
    line_start = 0;
  endtask

  task automatic rd(input logic [7:0] c, input logic [4:0] exp, input string tag);
    rd_col = c;
    step();
    chk(tag, 32'(rd_pixel), 32'(exp));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ready"}, 32'(wr_ready), 0);
    chk({tag, "_req"}, 32'(req_line), 0);
    chk({tag, "_pix"}, 32'(rd_pixel), 0);
    chk({tag, "_cnt"}, 32'(underrun_cnt), 0);
    chk({tag, "_sync"}, 32'(sync_err), 0);
  endtask

  initial begin
    step(); step();
    chk_reset("rst");
    rst = 0;
    step();
    chk("init_req", 32'(req_line), 1);
    chk("init_ready", 32'(wr_ready), 1);
    step();
    chk("init_req_off", 32'(req_line), 0);
    for (int i = 0; i < 188; i++) beat(5'(i % 32), i == 0);
    chk("full_ready", 32'(wr_ready), 0);
    chk("full_req", 32'(req_line), 0);
    pulse_line();
    chk("swap_req", 32'(req_line), 1);
    chk("swap_ready", 32'(wr_ready), 1);
    rd(8'd0, 5'd0, "l1_c0");
    chk("swap_req_off", 32'(req_line), 0);
    rd(8'd5, 5'd5, "l1_c5");
    rd(8'd187, 5'd27, "l1_c187");
    rd(8'd200, 5'd0, "l1_c200");
    chk("l1_cnt", 32'(underrun_cnt), 0);

    pulse_line();
    chk("ur_cnt", 32'(underrun_cnt), 1);
    chk("ur_ready", 32'(wr_ready), 1);
    rd(8'd5, 5'd0, "ur_c5");
    rd(8'd187, 5'd0, "ur_c187");

    for (int i = 0; i < 50; i++) beat(i == 0 ? 5'd9 : 5'((i + 7) % 32), i == 0);
    chk("pre_sync", 32'(sync_err), 0);
    beat(5'd21, 1'b1);
    chk("sync_err", 32'(sync_err), 1);
    for (int a = 1; a < 188; a++) beat(5'((a + 7) % 32), 1'b0);
    chk("sync_full_ready", 32'(wr_ready), 0);
    wr_valid = 1; wr_data = 5'd0;
    step();
    chk("extra_ready", 32'(wr_ready), 0);
    wr_valid = 0;
    pulse_line();
    chk("sync_swap_req", 32'(req_line), 1);
    chk("sync_swap_cnt", 32'(underrun_cnt), 1);
    rd(8'd0, 5'd21, "sync_c0");
    rd(8'd100, 5'd11, "sync_c100");
    rd(8'd187, 5'd2, "sync_c187");

    for (int a = 0; a < 187; a++) beat(5'((a + 3) % 32), a == 0);
    chk("coin_ready", 32'(wr_ready), 1);
    line_start = 1;
    beat(5'((187 + 3) % 32), 1'b0);
    line_start = 0;
    chk("coin_req", 32'(req_line), 1);
    chk("coin_cnt", 32'(underrun_cnt), 1);
    rd(8'd187, 5'd30, "coin_c187");
    rd(8'd0, 5'd3, "coin_c0");

    line_start = 1;
    for (int i = 0; i < 300; i++) step();
    line_start = 0;
    chk("sat_cnt", 32'(underrun_cnt), 255);
    pulse_line();
    chk("sat_hold", 32'(underrun_cnt), 255);
    rd(8'd5, 5'd0, "sat_blank");

    for (int i = 0; i < 100; i++) beat(5'd17, i == 0);
    rst = 1;
    step();
    rst = 0;
    chk_reset("mid_rst");
    step();
    chk("mid_init_req", 32'(req_line), 1);
    chk("mid_init_ready", 32'(wr_ready), 1);
    for (int a = 0; a < 188; a++) beat(5'((a + 13) % 32), a == 0);
    pulse_line();
    chk("mid_cnt", 32'(underrun_cnt), 0);
    rd(8'd50, 5'd31, "mid_c50");
    rd(8'd99, 5'd16, "mid_c99");
    rd(8'd150, 5'd3, "mid_c150");
    rd(8'd200, 5'd0, "mid_c200");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
